// File: rtl/niosii_microprocessor_pio_pkg.sv
// Shared definitions for the Nios II lab PIO blocks: register addresses,
// STATUS bit positions and the pulse engine state type.
package niosII_microprocessor_pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA     = 3'd0;
  localparam logic [2:0] PIO_ADDR_OUTSET   = 3'd2;
  localparam logic [2:0] PIO_ADDR_OUTCLEAR = 3'd3;
  localparam logic [2:0] PIO_ADDR_PULSE    = 3'd4;
  localparam logic [2:0] PIO_ADDR_STATUS   = 3'd5;

  localparam int PIO_STATUS_BUSY_BIT    = 0;
  localparam int PIO_STATUS_OVERRUN_BIT = 1;

  typedef enum logic {
    PIO_IDLE  = 1'b0,
    PIO_PULSE = 1'b1
  } pio_pulse_state_t;

  // Pulse counter width: $clog2 of the duration, never less than one bit.
  function automatic int pio_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/niosii_microprocessor_pulse_timer.sv
// Pulse engine: holds an inversion mask for exactly PULSE_CYCLES clocks.
//
// state     | meaning
// PIO_IDLE  | no pulse running, mask is zero, ready to start
// PIO_PULSE | mask applied, cnt counts down to the final cycle
//
// A start on the final cycle of a pulse (cnt == 0) is accepted as a clean
// restart so back-to-back pulses leave no gap; any earlier start is refused
// and reported through overrun_evt.
module niosII_microprocessor_pulse_timer
  import niosII_microprocessor_pio_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mask_in,
  output logic             busy,
  output logic             overrun_evt,
  output logic [WIDTH-1:0] mask_out
);

  localparam int             CW       = pio_cnt_width(PULSE_CYCLES);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(PULSE_CYCLES - 1);

  pio_pulse_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;

  // State, counter and mask registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PIO_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state logic: load on start, count down, release on terminal count.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    overrun_evt = 1'b0;
    case (state_q)
      PIO_IDLE: begin
        if (start && (mask_in != '0)) begin
          state_d = PIO_PULSE;
          cnt_d   = CNT_LOAD;
          mask_d  = mask_in;
        end
      end
      PIO_PULSE: begin
        if (cnt_q == '0) begin
          if (start && (mask_in != '0)) begin
            cnt_d  = CNT_LOAD;
            mask_d = mask_in;
          end else begin
            state_d = PIO_IDLE;
            mask_d  = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (start) overrun_evt = 1'b1;
        end
      end
      default: begin
        state_d = PIO_IDLE;
        cnt_d   = '0;
        mask_d  = '0;
      end
    endcase
  end

  assign busy     = (state_q == PIO_PULSE);
  assign mask_out = mask_q;

endmodule

// File: rtl/niosii_microprocessor_out_pio.sv
// Avalon-MM output PIO with atomic set/clear. The optional pulse engine
// (PULSE and STATUS registers) is built only when NIOS_OUT_PIO_PULSE_EN is
// defined; otherwise addresses 4 and 5 read zero and ignore writes.
module niosii_microprocessor_out_pio
  import niosII_microprocessor_pio_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             we;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] pulse_mask;
  logic             busy;
  logic             overrun_q;

  assign we = chipselect && !write_n;
  assign wd = writedata[WIDTH-1:0];

  // Bits above WIDTH are intentionally ignored.
  wire unused_writedata = &{1'b0, writedata};

`ifdef NIOS_OUT_PIO_PULSE_EN
  logic overrun_evt;
  logic overrun_d;

  niosII_microprocessor_pulse_timer #(
    .WIDTH        (WIDTH),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (we && (address == PIO_ADDR_PULSE)),
    .mask_in     (wd),
    .busy        (busy),
    .overrun_evt (overrun_evt),
    .mask_out    (pulse_mask)
  );

  // Sticky OVERRUN: set by a refused pulse start, cleared by writing 1 to bit1.
  always_comb begin
    overrun_d = overrun_q;
    if (we && (address == PIO_ADDR_STATUS) && writedata[PIO_STATUS_OVERRUN_BIT])
      overrun_d = 1'b0;
    if (overrun_evt)
      overrun_d = 1'b1;
  end

  // OVERRUN flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overrun_q <= 1'b0;
    else          overrun_q <= overrun_d;
  end
`else
  localparam int unused_pulse_cycles = PULSE_CYCLES;
  assign pulse_mask = '0;
  assign busy       = 1'b0;
  assign overrun_q  = 1'b0;
`endif

  // Data register update: plain load, atomic set, atomic clear.
  always_comb begin
    data_d = data_q;
    if (we) begin
      case (address)
        PIO_ADDR_DATA:     data_d = wd;
        PIO_ADDR_OUTSET:   data_d = data_q | wd;
        PIO_ADDR_OUTCLEAR: data_d = data_q & ~wd;
        default:           data_d = data_q;
      endcase
    end
  end

  // Read mux; sampled from the pre-write register values every cycle.
  always_comb begin
    readdata_d = '0;
    case (address)
      PIO_ADDR_DATA: readdata_d[WIDTH-1:0] = data_q;
`ifdef NIOS_OUT_PIO_PULSE_EN
      PIO_ADDR_PULSE: readdata_d[WIDTH-1:0] = pulse_mask;
      PIO_ADDR_STATUS: begin
        readdata_d[PIO_STATUS_BUSY_BIT]    = busy;
        readdata_d[PIO_STATUS_OVERRUN_BIT] = overrun_q;
      end
`endif
      default: readdata_d = '0;
    endcase
  end

  // Data and read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q ^ pulse_mask;

endmodule

// File: tb/tb_niosii_microprocessor_out_pio.sv
// Bench for niosii_microprocessor_out_pio (WIDTH=8, RESET_VALUE=8'hA5,
// PULSE_CYCLES=4). Works with NIOS_OUT_PIO_PULSE_EN defined or not.
module tb_niosii_microprocessor_out_pio;

  localparam int         P      = 4;
  localparam logic [7:0] RST_V  = 8'hA5;
`ifdef NIOS_OUT_PIO_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int total = 0;
  int bad   = 0;

  // Reference model: register contents plus "edges of pulse remaining".
  logic [7:0] m_data;
  logic [7:0] m_mask;
  int         m_rem;
  logic       m_ovr;

  niosii_microprocessor_out_pio #(
    .WIDTH        (8),
    .RESET_VALUE  (RST_V),
    .PULSE_CYCLES (P)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = RST_V;
    m_mask = 8'h00;
    m_rem  = 0;
    m_ovr  = 1'b0;
  endtask

  // Drive one bus cycle from a negedge, advance the model by one edge,
  // then compare at the following negedge.
  task automatic step(input logic cs, input logic wn, input logic [2:0] a,
                      input logic [31:0] d);
    logic [31:0] exp_rd;
    logic        we;
    logic        start;
    logic        ready;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;

    exp_rd = 32'h0;
    case (a)
      3'd0: exp_rd = {24'h0, m_data};
      3'd4: exp_rd = PULSE_EN ? {24'h0, m_mask} : 32'h0;
      3'd5: exp_rd = PULSE_EN ? {30'h0, m_ovr, (m_rem > 0)} : 32'h0;
      default: exp_rd = 32'h0;
    endcase

    we    = cs && !wn;
    start = we && (a == 3'd4) && PULSE_EN;
    ready = (m_rem <= 1);
    if (start && !ready) m_ovr = 1'b1;
    if (m_rem > 0) m_rem--;
    if (m_rem == 0) m_mask = 8'h00;
    if (start && ready && (d[7:0] != 8'h00)) begin
      m_rem  = P;
      m_mask = d[7:0];
    end
    if (we) begin
      case (a)
        3'd0: m_data = d[7:0];
        3'd2: m_data = m_data | d[7:0];
        3'd3: m_data = m_data & ~d[7:0];
        3'd5: if (PULSE_EN && d[1]) m_ovr = 1'b0;
        default: ;
      endcase
    end

    @(negedge clk);
    check("out_port", {24'h0, out_port}, {24'h0, m_data ^ m_mask});
    check("readdata", readdata, exp_rd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b1, 1'b1, a, 32'h0);
  endtask

  initial begin
    int   hi_cnt;
    logic seen1;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_out_port", {24'h0, out_port}, 32'h000000A5);
    check("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;

    rd(3'd0);
    check("read_data_after_reset", readdata, 32'h000000A5);

    wr(3'd0, 32'hFFFF_FF0F);
    check("data_write", {24'h0, out_port}, 32'h0F);
    wr(3'd2, 32'h0000_00C0);
    check("outset", {24'h0, out_port}, 32'hCF);
    wr(3'd3, 32'h0000_0003);
    check("outclear", {24'h0, out_port}, 32'hCC);
    rd(3'd2);
    check("read_outset_zero", readdata, 32'h0);
    rd(3'd3);
    check("read_outclear_zero", readdata, 32'h0);

    // Single pulse width.
    wr(3'd0, 32'h0);
    wr(3'd4, 32'h01);
    hi_cnt = int'(out_port[0]);
    for (int i = 0; i < 7; i++) begin
      rd(3'd5);
      hi_cnt += int'(out_port[0]);
    end
    check("pulse_width", hi_cnt, PULSE_EN ? P : 0);
    rd(3'd4);
    check("pulse_idle_mask", readdata, 32'h0);

    // Overrun during an active pulse.
    wr(3'd4, 32'h01);
    seen1 = out_port[1];
    wr(3'd4, 32'h02);
    seen1 |= out_port[1];
    for (int i = 0; i < 6; i++) begin
      rd(3'd5);
      seen1 |= out_port[1];
    end
    check("overrun_no_toggle", {31'h0, seen1}, 32'h0);
    check("overrun_set", readdata, PULSE_EN ? 32'h2 : 32'h0);
    wr(3'd5, 32'h2);
    rd(3'd5);
    check("overrun_clear", readdata, 32'h0);

    // Back-to-back pulses at the earliest accepted restart.
    wr(3'd4, 32'h10);
    for (int i = 0; i < P - 1; i++) rd(3'd5);
    wr(3'd4, 32'h20);
    for (int i = 0; i < P + 2; i++) rd(3'd5);

    // Data write while pulsing.
    wr(3'd4, 32'h01);
    wr(3'd0, 32'hF0);
    check("data_during_pulse", {24'h0, out_port}, PULSE_EN ? 32'hF1 : 32'hF0);
    for (int i = 0; i < P + 1; i++) rd(3'd0);
    check("data_after_pulse", {24'h0, out_port}, 32'hF0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] a;
      a = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom);
    end

    // Asynchronous reset in the middle of a pulse.
    wr(3'd0, 32'h3C);
    wr(3'd4, 32'h81);
    rd(3'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_out_port", {24'h0, out_port}, 32'h000000A5);
    check("async_reset_readdata", readdata, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd5);
    rd(3'd4);
    check("busy_after_reset", readdata, 32'h0);
    wr(3'd4, 32'h01);
    rd(3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
